dmem_uart_tx: RTL and testbench

Memory-mapped UART transmitter that sits as a responder on the core's data-memory bus, next to `dmem_bus`. The core writes bytes to a register; the block buffers them in a small FIFO and shifts them out on a serial line as 8N1 frames. The core learns FIFO and transmitter state through a read-only status register. Address decode is internal: the block reacts only when `addr_in` falls in its 16-byte window.

---
 rtl/dmem_uart_tx.sv | 275 +++++++++++++++++++++++++++
 tb/tb_dmem_uart_tx.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_uart_tx.sv
// dmem_uart_tx: memory-mapped 8N1 UART transmitter with a small TX byte FIFO.
// Latency: a byte pushed at edge N into an empty, idle block is popped at N+1 and its start bit drives tx from N+1.
// Backpressure: none on the bus; a push into a full FIFO with no pop that cycle is dropped and sets sticky overrun.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   data_in, addr_in    write data and byte address from the core
//   byteen              byte-lane enables for writes
//   mem_read, mem_write access strobes; the block only responds inside its 16-byte window
//   data_out            combinational read data (0 when not selected or not reading)
//   tx                  registered serial output, idle high
//
// Register map (word offsets inside the window):
//   0x0 TXDATA  W    byteen[0] pushes data_in[7:0]; reads 0
//   0x4 STATUS  R/W1C bit0 full, bit1 empty, bit2 busy, bit3 overrun (W1C), FIFO count from bit 8 up
//   0x8 BAUDDIV R/W  16-bit clock cycles per bit, byte-lane writable, 0 is stored as 1
//   0xC reserved

// dmem_uart_tx_fifo: circular-buffer FIFO whose push is accepted when not full or when a pop happens the same cycle.
// Latency: a push is visible at the head on the following cycle; head data is read combinationally.
// Backpressure: push_rdy_o low only when full with no pop; pops on an empty FIFO are ignored.
//
// Ports: push_vld_i/push_dat_i/push_rdy_o push side, pop_i pop request,
//        head_dat_o oldest entry, count_o/full_o/empty_o occupancy.
module dmem_uart_tx_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld_i,
  input  logic [DW-1:0]          push_dat_i,
  output logic                   push_rdy_o,
  input  logic                   pop_i,
  output logic [DW-1:0]          head_dat_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_acc;
  logic          pop_acc;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign pop_acc    = pop_i && !empty_o;
  // When full, the slot being freed by the pop is the one the write pointer
  // already points at; the pop reads it before the edge, the push overwrites it at the edge.
  assign push_rdy_o = !full_o || pop_acc;
  assign push_acc   = push_vld_i && push_rdy_o;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

module dmem_uart_tx #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int               FIFO_DEPTH  = 4,
  parameter logic [15:0]      DEFAULT_DIV = 16'd868
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] addr_in,
  input  logic [3:0]       byteen,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic [WIDTH-1:0] data_out,
  output logic             tx
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [15:0]   div_q, div_d;     // divider latched for the frame in flight
  logic [15:0]   cnt_q, cnt_d;     // cycles elapsed within the current bit
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic          tx_q, tx_d;
  logic          ovr_q, ovr_d;

  logic          sel;
  logic [1:0]    reg_off;
  logic          wr_en;
  logic          push_vld;
  logic          push_rdy;
  logic          pop;
  logic [7:0]    head_dat;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          busy;
  logic          bit_end;
  logic [15:0]   baud_merged;
  logic          unused_bits;

  assign sel      = (addr_in[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]);
  assign reg_off  = addr_in[3:2];
  assign wr_en    = sel && mem_write;
  assign push_vld = wr_en && (reg_off == 2'd0) && byteen[0];
  assign busy     = (state_q != S_IDLE);
  assign bit_end  = (cnt_q == div_q - 16'd1);
  assign tx       = tx_q;

  assign unused_bits = ^{addr_in[1:0], data_in[WIDTH-1:16], byteen[3:2]};

  dmem_uart_tx_fifo #(
    .DW    (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_vld_i (push_vld),
    .push_dat_i (data_in[7:0]),
    .push_rdy_o (push_rdy),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Register writes: BAUDDIV byte lanes and overrun (a dropped push beats a same-edge W1C).
  always_comb begin
    baud_merged = baud_q;
    if (byteen[0]) baud_merged[7:0]  = data_in[7:0];
    if (byteen[1]) baud_merged[15:8] = data_in[15:8];
    baud_d = baud_q;
    if (wr_en && (reg_off == 2'd2)) begin
      baud_d = (baud_merged == 16'd0) ? 16'd1 : baud_merged;
    end

    ovr_d = ovr_q;
    if (wr_en && (reg_off == 2'd1) && byteen[0] && data_in[3]) ovr_d = 1'b0;
    if (push_vld && !push_rdy) ovr_d = 1'b1;
  end

  // Transmit FSM: each of START, 8 DATA bits and STOP lasts div_q cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head_dat;
          div_d   = baud_q;
          cnt_d   = 16'd0;
          bit_d   = 3'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = 16'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d   = 16'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx is registered from the next state so the line is glitch-free.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= DEFAULT_DIV;
      div_q   <= DEFAULT_DIV;
      cnt_q   <= 16'd0;
      shift_q <= 8'd0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      ovr_q   <= ovr_d;
    end
  end

  // Read mux shows pre-edge state, so a simultaneous read+write returns the old value.
  always_comb begin
    data_out = '0;
    if (sel && mem_read) begin
      case (reg_off)
        2'd1: begin
          data_out[0]      = fifo_full;
          data_out[1]      = fifo_empty;
          data_out[2]      = busy;
          data_out[3]      = ovr_q;
          data_out[8 +: CW] = fifo_count;
        end
        2'd2:    data_out[15:0] = baud_q;
        default: data_out = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_uart_tx.sv
module tb_dmem_uart_tx;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 4;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_BD  = BASE + 32'h8;
  localparam logic [31:0] A_RS  = BASE + 32'hC;
  localparam int          MAXC  = 6000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in, addr_in, data_out;
  logic [3:0]  byteen;
  logic        mem_read, mem_write, tx;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  // Scenario schedule: one bus write per edge, relative to the scenario start.
  int          ev_n;
  int          ev_edge [64];
  logic [31:0] ev_addr [64];
  logic [31:0] ev_dat  [64];
  logic [3:0]  ev_be   [64];
  int          pr_n;
  int          pr_at  [4];
  logic [31:0] pr_exp [4];
  logic        exp_tx [MAXC];
  logic        exp_ovr;
  int          exp_len;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_uart_tx #(
    .WIDTH       (32),
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (16'd868)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .addr_in   (addr_in),
    .byteen    (byteen),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .data_out  (data_out),
    .tx        (tx)
  );

  task automatic idle_bus();
    mem_read = 1'b0; mem_write = 1'b0; byteen = 4'b0; data_in = '0; addr_in = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle_bus();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr_in = a; data_in = d; byteen = be; mem_write = 1'b1;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr_in = a; mem_read = 1'b1;
    #1 d = data_out;
    idle_bus();
  endtask

  task automatic add_ev(input int e, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    ev_edge[ev_n] = e; ev_addr[ev_n] = a; ev_dat[ev_n] = d; ev_be[ev_n] = be;
    ev_n++;
  endtask

  // BAUDDIV value in force before edge e, from the write history.
  function automatic int div_at(input int e);
    logic [15:0] d;
    d = 16'd868;
    for (int i = 0; i < ev_n; i++) begin
      if (ev_addr[i] == A_BD && ev_edge[i] < e) begin
        if (ev_be[i][0]) d[7:0]  = ev_dat[i][7:0];
        if (ev_be[i][1]) d[15:8] = ev_dat[i][15:8];
        if (d == 16'd0) d = 16'd1;
      end
    end
    return int'(d);
  endfunction

  // Reference model: each accepted byte becomes a 10-slot frame starting one edge after
  // the later of its push and the previous frame's end.
  task automatic model_build();
    int last_end, pe, d, t, cnt, slot;
    bit popnow;
    int pops[$];
    for (int k = 0; k < MAXC; k++) exp_tx[k] = 1'b1;
    exp_ovr = 1'b0; last_end = -1000; exp_len = 0;
    for (int i = 0; i < ev_n; i++) begin
      t = ev_edge[i];
      if (ev_addr[i] == A_TX && ev_be[i][0]) begin
        cnt = 0; popnow = 0;
        foreach (pops[j]) begin
          if (pops[j] >= t) cnt++;
          if (pops[j] == t) popnow = 1;
        end
        if (cnt < DEPTH || popnow) begin
          pe = (t + 1 > last_end + 1) ? t + 1 : last_end + 1;
          d  = div_at(pe);
          for (int k = 0; k < 10 * d; k++) begin
            slot = k / d;
            if (slot == 0)      exp_tx[pe + k] = 1'b0;
            else if (slot == 9) exp_tx[pe + k] = 1'b1;
            else                exp_tx[pe + k] = ev_dat[i][slot - 1];
          end
          last_end = pe + 10 * d;
          pops.push_back(pe);
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (ev_addr[i] == A_ST && ev_be[i][0] && ev_dat[i][3]) begin
        exp_ovr = 1'b0;
      end
      if (t > exp_len) exp_len = t;
    end
    if (last_end > exp_len) exp_len = last_end;
    exp_len += 2;
  endtask

  task automatic run_sched(input string nm);
    int base, ei;
    logic [31:0] rd, want;
    model_build();
    base = cyc; ei = 0;
    for (int k = 0; k <= exp_len; k++) begin
      if (k > 0) begin
        total++;
        if (tx !== exp_tx[k]) begin
          bad++; $display("FAIL %s tx at cycle %0d: got %b want %b", nm, k, tx, exp_tx[k]);
        end
      end
      for (int p = 0; p < pr_n; p++) begin
        if (pr_at[p] == k) begin
          bus_read(A_ST, rd); total++;
          if (rd !== pr_exp[p]) begin
            bad++; $display("FAIL %s status at cycle %0d: got %h want %h", nm, k, rd, pr_exp[p]);
          end
        end
      end
      if (ei < ev_n && ev_edge[ei] == k + 1) begin
        addr_in = ev_addr[ei]; data_in = ev_dat[ei]; byteen = ev_be[ei]; mem_write = 1'b1;
        ei++;
      end
      @(negedge clk);
      idle_bus();
    end
    want = exp_ovr ? 32'hA : 32'h2;
    bus_read(A_ST, rd); total++;
    if (rd !== want) begin
      bad++; $display("FAIL %s final status: got %h want %h", nm, rd, want);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset tx: got %b want 1", tx); end
    total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset idle data_out: got %h want 0", data_out); end
    bus_read(A_ST, rd); total++;
    if (rd !== 32'h2) begin bad++; $display("FAIL reset status: got %h want 2", rd); end
    bus_read(A_BD, rd); total++;
    if (rd !== 32'd868) begin bad++; $display("FAIL reset bauddiv: got %0d want 868", rd); end
    bus_read(A_TX, rd); total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL txdata read: got %h want 0", rd); end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd;
    do_reset();
    bus_write(A_BD, 32'd4, 4'b0011);
    bus_write(A_TX, 32'h00, 4'b0001);
    repeat (15) @(negedge clk);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL midframe tx before reset: got %b want 0", tx); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL midframe tx after reset: got %b want 1", tx); end
    bus_read(A_ST, rd); total++;
    if (rd !== 32'h2) begin bad++; $display("FAIL midframe status: got %h want 2", rd); end
    bus_read(A_BD, rd); total++;
    if (rd !== 32'd868) begin bad++; $display("FAIL midframe bauddiv: got %0d want 868", rd); end
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [31:0] rd;
    logic [9:0]  seq;
    seq = 10'b11_0100_1010;  // index 0 = first transmitted slot
    do_reset();
    bus_write(A_BD, 32'd4, 4'b0011);
    bus_write(A_TX, 32'hA5, 4'b0001);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL single tx before pop: got %b want 1", tx); end
    bus_read(A_ST, rd); total++;
    if (rd !== 32'h100) begin bad++; $display("FAIL single status after push: got %h want 100", rd); end
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      total++;
      if (tx !== seq[k / 4]) begin
        bad++; $display("FAIL single tx cycle %0d: got %b want %b", k, tx, seq[k / 4]);
      end
      if (k == 20) begin
        bus_read(A_ST, rd); total++;
        if (rd !== 32'h6) begin bad++; $display("FAIL single busy status: got %h want 6", rd); end
      end
      @(negedge clk);
    end
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL single tx after frame: got %b want 1", tx); end
    bus_read(A_ST, rd); total++;
    if (rd !== 32'h2) begin bad++; $display("FAIL single status after frame: got %h want 2", rd); end
    @(negedge clk);
  endtask

  task automatic test_fill_overrun();
    do_reset(); ev_n = 0; pr_n = 2;
    add_ev(1, A_BD, 32'd100, 4'b0011);
    for (int i = 0; i < 6; i++) add_ev(2 + i, A_TX, $urandom_range(0, 255), 4'b0001);
    add_ev(8, A_ST, 32'h8, 4'b0001);
    pr_at[0] = 7; pr_exp[0] = 32'h40D;  // full, busy, overrun, count 4
    pr_at[1] = 8; pr_exp[1] = 32'h405;  // overrun cleared only
    run_sched("fill");
  endtask

  task automatic test_collision();
    do_reset(); ev_n = 0; pr_n = 2;
    add_ev(1, A_BD, 32'd4, 4'b0011);
    for (int i = 0; i < 5; i++) add_ev(2 + i, A_TX, $urandom_range(0, 255), 4'b0001);
    // first frame pops at 3 and ends at 3+40; the next pop is one idle cycle later
    add_ev(3 + 40 + 1, A_TX, $urandom_range(0, 255), 4'b0001);
    pr_at[0] = 43; pr_exp[0] = 32'h401;  // idle between frames, full
    pr_at[1] = 44; pr_exp[1] = 32'h405;  // push+pop: still 4, no overrun
    run_sched("collision");
  endtask

  task automatic test_baud_corner();
    logic [31:0] rd;
    do_reset();
    bus_write(A_BD, 32'd0, 4'b0011);
    bus_read(A_BD, rd); total++;
    if (rd !== 32'd1) begin bad++; $display("FAIL bauddiv zero: got %0d want 1", rd); end
    @(negedge clk);
    do_reset(); ev_n = 0; pr_n = 0;
    add_ev(1, A_BD, 32'd0, 4'b0011);
    add_ev(2, A_TX, $urandom_range(0, 255), 4'b0001);
    add_ev(3, A_TX, $urandom_range(0, 255), 4'b0001);
    add_ev(5, A_BD, 32'd8, 4'b0011);
    run_sched("baud_corner");
  endtask

  task automatic test_decode();
    logic [31:0] rd;
    do_reset();
    bus_write(BASE + 32'h10, 32'h55, 4'b0001);
    bus_write(A_RS, 32'hFFFF_FFFF, 4'b1111);
    @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL decode tx: got %b want 1", tx); end
    bus_read(A_ST, rd); total++;
    if (rd !== 32'h2) begin bad++; $display("FAIL decode no push: got %h want 2", rd); end
    bus_read(A_RS, rd); total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL decode reserved read: got %h want 0", rd); end
    bus_read(BASE + 32'h18, rd); total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL decode outside read: got %h want 0", rd); end
    @(negedge clk);
    bus_write(A_BD, 32'h0000_AB77, 4'b0010);
    bus_read(A_BD, rd); total++;
    if (rd !== 32'h0000_AB64) begin bad++; $display("FAIL decode partial byteen: got %h want ab64", rd); end
    @(negedge clk);
    addr_in = A_BD; data_in = 32'h1234; byteen = 4'b0011; mem_read = 1'b1; mem_write = 1'b1;
    #1 rd = data_out; total++;
    if (rd !== 32'h0000_AB64) begin bad++; $display("FAIL rd+wr pre-write value: got %h want ab64", rd); end
    @(negedge clk);
    idle_bus();
    addr_in = A_BD;
    #1 total++;
    if (data_out !== 32'h0) begin bad++; $display("FAIL no read strobe: got %h want 0", data_out); end
    bus_read(A_BD, rd); total++;
    if (rd !== 32'h1234) begin bad++; $display("FAIL rd+wr committed: got %h want 1234", rd); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int e, d;
    for (int it = 0; it < 3; it++) begin
      do_reset(); ev_n = 0; pr_n = 0;
      d = int'($urandom_range(1, 4));
      add_ev(1, A_BD, d, 4'b0011);
      e = 2;
      for (int i = 0; i < 20; i++) begin
        add_ev(e, A_TX, $urandom_range(0, 255), 4'b0001);
        e += 1 + int'($urandom_range(0, 6 * d));
        if (i == 10) begin
          add_ev(e, A_ST, 32'h8, 4'b0001);
          e++;
        end
      end
      run_sched("random");
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_bus();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_reset_midframe();
    test_single_byte();
    test_fill_overrun();
    test_collision();
    test_baud_corner();
    test_decode();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
